jtframe_frac_cen_mc: RTL and testbench
======================================

# jtframe_frac_cen_mc

Multi-channel fractional clock-enable generator. It produces CH independent enable streams, each at rate n/m of `cen_in`. Each channel provides W power-of-two divided outputs and matching 180°-shifted outputs. Ratios can be reloaded at runtime without glitches, and an optional catch-up mode lets a channel close a pulse-count deficit against an external target. It sits in the clocking layer between the master clock-enable and the CPU, sound and video cores, and replaces the single-channel generators.

## Interface
Parameters:
- CH, 2 — number of channels (≥1)
- W, 2 — divided outputs per channel (≥1; output k fires every 2^k base pulses)
- CW, 10 — width of n, m, n2
- TW, 10 — width of the pulse counter and target

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen_in  in  1  master enable; all channel activity is qualified by it
- ch_en  in  CH  per-channel run enable
- ld  in  CH  per-channel load strobe for n/m/n2
- n  in  CH*CW  numerator, channel c at [c*CW +: CW]
- m  in  CH*CW  denominator
- n2  in  CH*CW  catch-up numerator
- target  in  CH*TW  catch-up pulse-count target
- cen  out  CH*W  enables, channel c at [c*W +: W]
- cenb  out  CH*W  180°-shifted enables
- count  out  CH*TW  emitted base-pulse count per channel
- lag  out  CH  high while the channel is in a catch-up period

## Operation
- Per channel, the following registers reset to 0: acc (CW+1 bits), half, edgecnt (W bits), active n/m/n2, pending n/m/n2, pend flag, count, catchup. All outputs are 0 during reset.
- Load:
  - `ld[c]` captures n/m/n2 into the pending registers and sets pend. A second ld before apply overwrites the pending values.
  - If `ch_en[c]`=0 or active m=0, pending values are applied on the next clk edge, acc clears, and pend clears.
  - Otherwise pending values are applied at the next over event, and that event's acc update uses the old ratio.
- Step: step = catchup ? n2 : n. next = acc+step and next2 = next−m, both at CW+1 bits with no overflow possible because n,m < 2^CW.
- Channel idle (no pulses, acc frozen) when `ch_en[c]`=0 or m=0.
- On a `cen_in` cycle with the channel running:
  - If acc ≥ m+step (corrupt state), acc←0 and no pulse is emitted.
  - Else halfway = (next ≥ m>>1) && !half. Halfway sets half and fires cenb[0].
  - over = next ≥ m. On over:
    - acc←next2, half←0, edgecnt←edgecnt+1, count←count+1.
    - cen[0] fires.
    - cen[k] (k≥1) fires if the new edgecnt[k-1:0] is 0.
    - cenb[k] (k≥1) fires if the new edgecnt[k-1:0] is 2^(k-1).
  - Otherwise acc←next.
- Halfway and over in the same cycle: both fire.
- Catch-up: at each over event, catchup←(target ≠ count+1), where count+1 is the post-increment value. catchup selects n2 for the following period.
- lag = catchup.
- count wraps modulo 2^TW, and the target comparison is modular.
- ch_en falling mid-period: acc, half and edgecnt hold, and the channel resumes exactly where it stopped.

## Timing
- All outputs are registered. Pulses are one clk wide, in the cycle after the qualifying `cen_in` cycle.
- With n/m constant and no catch-up, cen[0] period = m/n `cen_in` cycles, averaged exactly with no drift.
- ld to effective ratio: 1 clk when the channel is idle, otherwise the first over event after the ld edge.
- Reset assertion clears all state asynchronously. Deassertion is assumed synchronised upstream.

## Configuration
- JTFRAME_FRAC_CEN_CATCHUP_EN defined: catch-up logic as described above.
- Undefined: n2 and target are ignored, catchup and lag are tied to 0, and count still operates.

## Structure
- Package jtframe_frac_cen_pkg holds the channel-state struct type, the bit-slice helper for the packed ports, and default parameter constants.
- One sub-module, jtframe_frac_cen_ch, implements a single channel. The top level generates CH instances and packs their outputs.

## Test plan
- CH=2, W=2, ch0 n=1 m=4, `cen_in` always 1:
  - cenb[0] fires on the 2nd cycle, cen[0] on the 4th.
  - cen[0] repeats every 4 cycles, cen[1] every 8, cenb[1] midway between cen[1] pulses.
- ch1 n=3 m=10 over 1000 `cen_in` cycles → exactly 300 cen[0] pulses, with no channel interaction.
- Reload mid-period: ch0 running 1/4, ld with n=1 m=2 at acc=1:
  - The current period completes under the 1/4 ratio.
  - Subsequent pulses come every 2 cycles.
- ch_en low for 5 cycles at acc=2, then high → next cen[0] after 2 more running cycles. Force acc corrupt (≥m+step) → acc restarts at 0.
- Catch-up (macro on): n=1 n2=2 m=4, target=count+3:
  - lag rises after the first over event.
  - Periods shorten to 2 cycles until count reaches target, then lag falls.
  - Same stimulus with the macro off → lag stays 0.
- Assert rst_n low mid-period → all outputs go 0 immediately. After release, the channel stays idle until ld.

Source files
------------

// File: rtl/jtframe_frac_cen_pkg.sv
// Shared types, default sizes and packed-port slicing helper for the
// multi-channel fractional clock-enable generator.
package jtframe_frac_cen_pkg;

    localparam int CH_DEF = 2;
    localparam int W_DEF  = 2;
    localparam int CW_DEF = 10;
    localparam int TW_DEF = 10;

    typedef struct packed {
        logic half;     // halfway pulse already emitted this period
        logic pend;     // pending ratio waiting to be applied
        logic catchup;  // period runs on n2 instead of n
    } ch_flags_t;

    function automatic int lo_bit(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/jtframe_frac_cen_if.sv
// Bundle of per-channel ratio controls and enable outputs; master drives
// ratios and the run/load strobes, slave (the generator) returns the enables.
interface jtframe_frac_cen_if
    import jtframe_frac_cen_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF,
    parameter int TW = TW_DEF
);
    logic               cen_in;
    logic [CH-1:0]      ch_en;
    logic [CH-1:0]      ld;
    logic [CH*CW-1:0]   n;
    logic [CH*CW-1:0]   m;
    logic [CH*CW-1:0]   n2;
    logic [CH*TW-1:0]   target;
    logic [CH*W-1:0]    cen;
    logic [CH*W-1:0]    cenb;
    logic [CH*TW-1:0]   count;
    logic [CH-1:0]      lag;

    modport master (
        output cen_in, ch_en, ld, n, m, n2, target,
        input  cen, cenb, count, lag
    );

    modport slave (
        input  cen_in, ch_en, ld, n, m, n2, target,
        output cen, cenb, count, lag
    );
endinterface

// File: rtl/jtframe_frac_cen_ch.sv
// One fractional enable channel: registered pulses one clk after the qualifying
// cen_i cycle, no backpressure. Catch-up period selection under JTFRAME_FRAC_CEN_CATCHUP_EN.
module jtframe_frac_cen_ch
    import jtframe_frac_cen_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_i,
    input  logic          en_i,
    input  logic          ld_i,
    input  logic [CW-1:0] n_i,
    input  logic [CW-1:0] m_i,
    input  logic [CW-1:0] n2_i,
    input  logic [TW-1:0] target_i,
    output logic [W-1:0]  cen_o,
    output logic [W-1:0]  cenb_o,
    output logic [TW-1:0] count_o,
    output logic          lag_o
);
    logic [CW:0]   acc_q, acc_d;
    logic [W-1:0]  edge_q, edge_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] n_q, n_d, m_q, m_d, n2_q, n2_d;
    logic [CW-1:0] pn_q, pn_d, pm_q, pm_d, pn2_q, pn2_d;
    ch_flags_t     fl_q, fl_d;
    logic [W-1:0]  cen_q, cen_d, cenb_q, cenb_d;

    logic          idle, run, corrupt, halfway, over, apply;
    logic [CW:0]   step, nxt, nxt2;
    logic [W-1:0]  edge_inc, mask;
    logic [TW-1:0] cnt_inc;

    always_comb begin
        idle     = !en_i || (m_q == '0);
        run      = cen_i && !idle;
        step     = {1'b0, fl_q.catchup ? n2_q : n_q};
        nxt      = acc_q + step;
        nxt2     = nxt - {1'b0, m_q};
        corrupt  = acc_q >= ({1'b0, m_q} + step);
        halfway  = (nxt >= {1'b0, m_q >> 1}) && !fl_q.half;
        over     = nxt >= {1'b0, m_q};
        edge_inc = edge_q + W'(1);
        cnt_inc  = cnt_q + TW'(1);
        // A running channel only switches ratio on a period boundary
        apply    = fl_q.pend && (idle || (run && !corrupt && over));
    end

    always_comb begin
        acc_d  = acc_q;
        edge_d = edge_q;
        cnt_d  = cnt_q;
        fl_d   = fl_q;
        n_d    = n_q;
        m_d    = m_q;
        n2_d   = n2_q;
        pn_d   = pn_q;
        pm_d   = pm_q;
        pn2_d  = pn2_q;
        cen_d  = '0;
        cenb_d = '0;
        mask   = '0;

        if (run && corrupt) begin
            acc_d = '0;
        end else if (run) begin
            if (halfway) begin
                fl_d.half = 1'b1;
                cenb_d[0] = 1'b1;
            end
            if (over) begin
                acc_d     = nxt2;
                fl_d.half = 1'b0;
                edge_d    = edge_inc;
                cnt_d     = cnt_inc;
                cen_d[0]  = 1'b1;
                for (int k = 1; k < W; k++) begin
                    mask      = (W'(1) << k) - W'(1);
                    cen_d[k]  = (edge_inc & mask) == '0;
                    cenb_d[k] = (edge_inc & mask) == (W'(1) << (k - 1));
                end
`ifdef JTFRAME_FRAC_CEN_CATCHUP_EN
                fl_d.catchup = target_i != cnt_inc;
`endif
            end else begin
                acc_d = nxt;
            end
        end

        if (apply) begin
            n_d       = pn_q;
            m_d       = pm_q;
            n2_d      = pn2_q;
            fl_d.pend = 1'b0;
            if (idle) acc_d = '0;
        end
        if (ld_i) begin
            pn_d      = n_i;
            pm_d      = m_i;
            pn2_d     = n2_i;
            fl_d.pend = 1'b1;
        end
    end

`ifndef JTFRAME_FRAC_CEN_CATCHUP_EN
    logic unused_target;
    assign unused_target = ^target_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            edge_q <= '0;
            cnt_q  <= '0;
            fl_q   <= '0;
            n_q    <= '0;
            m_q    <= '0;
            n2_q   <= '0;
            pn_q   <= '0;
            pm_q   <= '0;
            pn2_q  <= '0;
            cen_q  <= '0;
            cenb_q <= '0;
        end else begin
            acc_q  <= acc_d;
            edge_q <= edge_d;
            cnt_q  <= cnt_d;
            fl_q   <= fl_d;
            n_q    <= n_d;
            m_q    <= m_d;
            n2_q   <= n2_d;
            pn_q   <= pn_d;
            pm_q   <= pm_d;
            pn2_q  <= pn2_d;
            cen_q  <= cen_d;
            cenb_q <= cenb_d;
        end
    end

    assign cen_o   = cen_q;
    assign cenb_o  = cenb_q;
    assign count_o = cnt_q;
    assign lag_o   = fl_q.catchup;

endmodule

// File: rtl/jtframe_frac_cen_mc.sv
// CH independent n/m fractional enable channels packed onto one bus; 1 clk
// registered latency, no backpressure. Catch-up via JTFRAME_FRAC_CEN_CATCHUP_EN.
module jtframe_frac_cen_mc
    import jtframe_frac_cen_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    jtframe_frac_cen_if.slave bus
);
    logic [W-1:0]  cen_w   [CH];
    logic [W-1:0]  cenb_w  [CH];
    logic [TW-1:0] count_w [CH];
    logic          lag_w   [CH];

    for (genvar c = 0; c < CH; c++) begin : g_ch
        jtframe_frac_cen_ch #(
            .W  (W),
            .CW (CW),
            .TW (TW)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cen_i    (bus.cen_in),
            .en_i     (bus.ch_en[c]),
            .ld_i     (bus.ld[c]),
            .n_i      (bus.n[lo_bit(c, CW) +: CW]),
            .m_i      (bus.m[lo_bit(c, CW) +: CW]),
            .n2_i     (bus.n2[lo_bit(c, CW) +: CW]),
            .target_i (bus.target[lo_bit(c, TW) +: TW]),
            .cen_o    (cen_w[c]),
            .cenb_o   (cenb_w[c]),
            .count_o  (count_w[c]),
            .lag_o    (lag_w[c])
        );
    end

    always_comb begin
        bus.cen   = '0;
        bus.cenb  = '0;
        bus.count = '0;
        bus.lag   = '0;
        for (int c = 0; c < CH; c++) begin
            bus.cen[lo_bit(c, W) +: W]     = cen_w[c];
            bus.cenb[lo_bit(c, W) +: W]    = cenb_w[c];
            bus.count[lo_bit(c, TW) +: TW] = count_w[c];
            bus.lag[c]                     = lag_w[c];
        end
    end

endmodule

// File: tb/tb_jtframe_frac_cen_mc.sv
// Directed bench for the multi-channel fractional enable generator, with
// hand-derived pulse schedules for each scenario.
module tb_jtframe_frac_cen_mc;
    localparam int CH = 2;
    localparam int W  = 2;
    localparam int CW = 10;
    localparam int TW = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    jtframe_frac_cen_if #(.CH(CH), .W(W), .CW(CW), .TW(TW)) bus ();

    jtframe_frac_cen_mc #(.CH(CH), .W(W), .CW(CW), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input int nv, input int mv, input int n2v, input int tv);
        bus.n[c*CW +: CW]      = CW'(nv);
        bus.m[c*CW +: CW]      = CW'(mv);
        bus.n2[c*CW +: CW]     = CW'(n2v);
        bus.target[c*TW +: TW] = TW'(tv);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.cen_in = 1'b1;
        bus.ch_en  = '0;
        bus.ld     = '0;
        bus.n      = '0;
        bus.m      = '0;
        bus.n2     = '0;
        bus.target = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Load ch0 while idle: one edge to capture, one edge to apply.
    task automatic start0(input int nv, input int mv, input int n2v, input int tv);
        set_ch(0, nv, mv, n2v, tv);
        bus.ch_en[0] = 1'b1;
        bus.ld[0]    = 1'b1;
        tick();
        bus.ld[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.cen_in = 1'b1;
        bus.ch_en  = 2'b11;
        bus.ld     = 2'b11;
        set_ch(0, 1, 4, 0, 0);
        set_ch(1, 1, 2, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.cen !== '0) begin
            failures++;
            $display("FAIL reset_cen got=%b want=0", bus.cen);
        end
        checks++;
        if (bus.cenb !== '0) begin
            failures++;
            $display("FAIL reset_cenb got=%b want=0", bus.cenb);
        end
        checks++;
        if (bus.count !== '0) begin
            failures++;
            $display("FAIL reset_count got=%h want=0", bus.count);
        end
        checks++;
        if (bus.lag !== '0) begin
            failures++;
            $display("FAIL reset_lag got=%b want=0", bus.lag);
        end
        bus.ld = '0;
        rst_n  = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] exp_cen, exp_cenb;
        do_reset();
        start0(1, 4, 0, 0);
        for (int t = 1; t <= 16; t++) begin
            tick();
            exp_cen  = {2'b00, (t % 8) == 0, (t % 4) == 0};
            exp_cenb = {2'b00, (t % 8) == 4, (t % 4) == 2};
            checks++;
            if ({bus.cenb, bus.cen} !== {exp_cenb, exp_cen}) begin
                failures++;
                $display("FAIL basic t=%0d cen=%b cenb=%b want cen=%b cenb=%b",
                         t, bus.cen, bus.cenb, exp_cen, exp_cenb);
            end
        end
        checks++;
        if (bus.count !== {TW'(0), TW'(4)}) begin
            failures++;
            $display("FAIL basic_count got=%h want ch0=4 ch1=0", bus.count);
        end
    endtask

    task automatic test_ratio();
        int p0 = 0;
        int p1 = 0;
        int h1 = 0;
        do_reset();
        set_ch(0, 1, 4, 0, 0);
        set_ch(1, 3, 10, 0, 0);
        bus.ch_en = 2'b11;
        bus.ld    = 2'b11;
        tick();
        bus.ld = 2'b00;
        tick();
        for (int t = 0; t < 1000; t++) begin
            tick();
            if (bus.cen[0])  p0++;
            if (bus.cen[2])  p1++;
            if (bus.cenb[2]) h1++;
        end
        checks++;
        if (p1 != 300) begin
            failures++;
            $display("FAIL ratio_ch1_pulses got=%0d want=300", p1);
        end
        checks++;
        if (h1 != 300) begin
            failures++;
            $display("FAIL ratio_ch1_half got=%0d want=300", h1);
        end
        checks++;
        if (p0 != 250) begin
            failures++;
            $display("FAIL ratio_ch0_pulses got=%0d want=250", p0);
        end
        checks++;
        if (bus.count[TW +: TW] !== TW'(300)) begin
            failures++;
            $display("FAIL ratio_ch1_count got=%0d want=300", bus.count[TW +: TW]);
        end
        checks++;
        if (bus.count[0 +: TW] !== TW'(250)) begin
            failures++;
            $display("FAIL ratio_ch0_count got=%0d want=250", bus.count[0 +: TW]);
        end
    endtask

    task automatic test_reload();
        logic [1:0] exp_cen, exp_cenb;
        do_reset();
        start0(1, 4, 0, 0);
        for (int t = 1; t <= 10; t++) begin
            if (t == 2) begin
                set_ch(0, 1, 2, 0, 0);
                bus.ld[0] = 1'b1;
            end else begin
                bus.ld[0] = 1'b0;
            end
            tick();
            exp_cen  = {(t == 6) || (t == 10), (t >= 4) && ((t % 2) == 0)};
            exp_cenb = {(t == 4) || (t == 8), (t == 2) || ((t >= 5) && ((t % 2) == 1))};
            checks++;
            if ({bus.cenb[1:0], bus.cen[1:0]} !== {exp_cenb, exp_cen}) begin
                failures++;
                $display("FAIL reload t=%0d cen=%b cenb=%b want cen=%b cenb=%b",
                         t, bus.cen[1:0], bus.cenb[1:0], exp_cen, exp_cenb);
            end
        end
    endtask

    task automatic test_ch_en();
        logic [1:0] exp_cen, exp_cenb;
        do_reset();
        start0(1, 4, 0, 0);
        for (int t = 1; t <= 9; t++) begin
            bus.ch_en[0] = !((t >= 3) && (t <= 7));
            tick();
            exp_cen  = {1'b0, t == 9};
            exp_cenb = {t == 9, t == 2};
            checks++;
            if ({bus.cenb[1:0], bus.cen[1:0]} !== {exp_cenb, exp_cen}) begin
                failures++;
                $display("FAIL ch_en t=%0d cen=%b cenb=%b want cen=%b cenb=%b",
                         t, bus.cen[1:0], bus.cenb[1:0], exp_cen, exp_cenb);
            end
        end
        checks++;
        if (bus.count[0 +: TW] !== TW'(1)) begin
            failures++;
            $display("FAIL ch_en_count got=%0d want=1", bus.count[0 +: TW]);
        end
    endtask

    // Ratio 7/8 switched to 1/2 at an over event leaving acc=6, which is
    // beyond the new m+step and must be discarded.
    task automatic test_corrupt();
        logic [3:0] exp_v [1:5];
        exp_v[1] = 4'b0100;
        exp_v[2] = 4'b1001;
        exp_v[3] = 4'b0000;
        exp_v[4] = 4'b0100;
        exp_v[5] = 4'b0011;
        do_reset();
        start0(7, 8, 0, 0);
        for (int t = 1; t <= 5; t++) begin
            if (t == 1) begin
                set_ch(0, 1, 2, 0, 0);
                bus.ld[0] = 1'b1;
            end else begin
                bus.ld[0] = 1'b0;
            end
            tick();
            checks++;
            if ({bus.cenb[1:0], bus.cen[1:0]} !== exp_v[t]) begin
                failures++;
                $display("FAIL corrupt t=%0d cenb_cen=%b want=%b",
                         t, {bus.cenb[1:0], bus.cen[1:0]}, exp_v[t]);
            end
        end
    endtask

    task automatic test_catchup();
        logic exp_cen, exp_lag;
        do_reset();
        start0(1, 4, 2, 3);
        for (int t = 1; t <= 12; t++) begin
            tick();
`ifdef JTFRAME_FRAC_CEN_CATCHUP_EN
            exp_cen = (t == 4) || (t == 6) || (t == 8) || (t == 12);
            exp_lag = (t >= 4) && (t <= 7);
`else
            exp_cen = (t % 4) == 0;
            exp_lag = 1'b0;
`endif
            checks++;
            if (bus.cen[0] !== exp_cen) begin
                failures++;
                $display("FAIL catchup_cen t=%0d got=%b want=%b", t, bus.cen[0], exp_cen);
            end
            if (t <= 11) begin
                checks++;
                if (bus.lag[0] !== exp_lag) begin
                    failures++;
                    $display("FAIL catchup_lag t=%0d got=%b want=%b", t, bus.lag[0], exp_lag);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset();
        start0(1, 4, 0, 0);
        for (int t = 1; t <= 4; t++) tick();
        checks++;
        if (bus.cen[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=%b want=1", bus.cen[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.cen, bus.cenb, bus.lag} !== '0 || bus.count !== '0) begin
            failures++;
            $display("FAIL rstmid_async cen=%b cenb=%b count=%h lag=%b want all 0",
                     bus.cen, bus.cenb, bus.count, bus.lag);
        end
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.cen != '0 || bus.cenb != '0) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.count !== '0) begin
            failures++;
            $display("FAIL rstmid_idle pulses=%0d count=%h want 0 and 0", pulses, bus.count);
        end
        start0(1, 4, 0, 0);
        for (int t = 1; t <= 4; t++) tick();
        checks++;
        if (bus.cen[1:0] !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_restart got=%b want=01", bus.cen[1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ratio();
        test_reload();
        test_ch_en();
        test_corrupt();
        test_catchup();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
